// File: rtl/game_input_conditioner_if.sv
// Conditioned game-input bundle: raw buttons/switches in, clean pulses/levels/tick out.
interface game_input_conditioner_if;
    logic [1:0] key_n;
    logic [3:0] sw;
    logic       tick_en;
    logic [1:0] key_press;
    logic [1:0] key_level;
    logic [3:0] sw_sync;
    logic       sec_tick;

    modport master (
        output key_n, sw, tick_en,
        input  key_press, key_level, sw_sync, sec_tick
    );

    modport slave (
        input  key_n, sw, tick_en,
        output key_press, key_level, sw_sync, sec_tick
    );
endinterface

// File: rtl/game_input_conditioner.sv
// Synchronizes and debounces the game pushbuttons, synchronizes the guess switches,
// and divides the system clock into a gated seconds tick.
module gic_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic p,
    output logic key_press,
    output logic key_level
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          level_q, level_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            IDLE: if (p) begin
                state_d = PRESS_WAIT;
                cnt_d   = '0;
            end
            PRESS_WAIT: begin
                // A drop on the accept cycle still counts as a bounce.
                if (!p) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: if (!p) begin
                state_d = RELEASE_WAIT;
                cnt_d   = '0;
            end
            RELEASE_WAIT: begin
                if (p) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    assign key_press = press_q;
    assign key_level = level_q;
endmodule

module game_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 50_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    game_input_conditioner_if.slave  bus
);
    localparam int NUM_KEYS = 2;
    localparam int SW_W     = 4;
    localparam int TW       = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [SW_W-1:0]     sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                sec_tick_q, sec_tick_d;
    logic [NUM_KEYS-1:0] key_press_w, key_level_w;

    // Key synchronizers reset to the released level so a held key reads as a fresh press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_s1_q   <= '1;
            key_s2_q   <= '1;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            tick_cnt_q <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            key_s1_q   <= key_s1_d;
            key_s2_q   <= key_s2_d;
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            tick_cnt_q <= tick_cnt_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    always_comb begin
        key_s1_d   = bus.key_n;
        key_s2_d   = key_s1_q;
        sw_s1_d    = bus.sw;
        sw_s2_d    = sw_s1_q;
        tick_cnt_d = '0;
        sec_tick_d = 1'b0;
        if (bus.tick_en) begin
            if (tick_cnt_q == TICK_MAX) begin
                sec_tick_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        gic_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock     (clock),
            .reset     (reset),
            .p         (~key_s2_q[i]),
            .key_press (key_press_w[i]),
            .key_level (key_level_w[i])
        );
    end

    assign bus.key_press = key_press_w;
    assign bus.key_level = key_level_w;
    assign bus.sw_sync   = sw_s2_q;
    assign bus.sec_tick  = sec_tick_q;
endmodule
